// File: rtl/game_pkg.sv
// Shared types and helpers for the Grinch play controller: round states,
// heading encodings, grid size and the LFSR step used for gift placement.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLACE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Opposite headings differ only in bit 1 (left/right, up/down).
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return {~d[1], d[0]};
    endfunction

    // Right-shifting Fibonacci form of taps 16,14,13,11.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

endpackage

// File: rtl/game_sequencer_dir_queue.sv
// Two-entry direction request FIFO that drops requests repeating or reversing
// the most recent heading (queue tail, or current heading when empty).
module dir_queue
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       accept_en,
    input  logic       req_valid,
    input  logic [1:0] req_dir,
    input  logic [1:0] cur_dir,
    input  logic       pop,
    output logic [1:0] head,
    output logic       not_empty
);

    logic [1:0][1:0] entry_q, entry_d;
    logic [1:0]      count_q, count_d;
    logic [1:0]      tail;
    logic            reject;
    logic            push;
    logic            do_pop;

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        tail    = (count_q == 2'd0) ? cur_dir :
                  (count_q == 2'd2) ? entry_q[1] : entry_q[0];
        // Filter uses the pre-pop tail and pre-pop fullness.
        reject  = (req_dir == tail) || (req_dir == dir_opposite(tail)) || (count_q == 2'd2);
        push    = req_valid && accept_en && !reject;
        do_pop  = pop && (count_q != 2'd0);

        if (clear) begin
            count_d = 2'd0;
        end else begin
            if (do_pop) begin
                entry_d[0] = entry_q[1];
                count_d    = count_q - 2'd1;
            end
            if (push) begin
                entry_d[count_d[0]] = req_dir;
                count_d             = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            count_q <= 2'd0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign head      = entry_q[0];
    assign not_empty = (count_q != 2'd0);

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer for the Grinch game: state machine, move tick, gift placement
// handshake and direction queue. Define SPEEDUP_EN to shorten the tick period as gifts accumulate.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV  = 1562500,
    parameter int WIN_COUNT = 10,
    parameter int MAX_RETRY = 64,
    parameter int TICK_STEP = 62500
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       dir_req_valid,
    input  logic [1:0] dir_req,
    input  logic       gift_eaten,
    input  logic       game_over_in,
    input  logic [7:0] gift_count,
    output logic       place_req,
    output logic [5:0] place_x,
    output logic [5:0] place_y,
    input  logic       place_ack,
    input  logic       place_ok,
    output logic       move_tick,
    output logic [1:0] direction,
    output logic [2:0] state
);

    localparam int CNT_W   = $clog2(TICK_DIV + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    state_t             state_q, state_d;
    logic [1:0]         dir_q, dir_d;
    logic               tick_q, tick_d;
    logic               req_q, req_d;
    logic [5:0]         px_q, px_d, py_q, py_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cur_period;

    logic [5:0] raw_x, raw_y, cand_x, cand_y;
    logic       q_pop, q_clear, q_accept, q_not_empty;
    logic [1:0] q_head;

`ifdef SPEEDUP_EN
    logic [CNT_W-1:0] period_q, period_d;

    function automatic logic [CNT_W-1:0] speed_period(input logic [7:0] gc);
        int lvl;
        lvl = int'(gc >> 1);
        if (lvl > 7) lvl = 7;
        return CNT_W'(TICK_DIV - lvl * TICK_STEP);
    endfunction

    assign cur_period = period_q;
`else
    assign cur_period = CNT_W'(TICK_DIV);
`endif

    assign raw_x    = lfsr_q[5:0];
    assign raw_y    = {1'b0, lfsr_q[12:8]};
    assign cand_x   = (raw_x >= 6'(GRID_W)) ? raw_x - 6'(GRID_W) : raw_x;
    assign cand_y   = (raw_y >= 6'(GRID_H)) ? raw_y - 6'(GRID_H) : raw_y;
    assign q_accept = (state_q == ST_PLAY) || (state_q == ST_PLACE);

    dir_queue u_dir_queue (
        .clk       (vga_clk),
        .rst_n     (reset),
        .clear     (q_clear),
        .accept_en (q_accept),
        .req_valid (dir_req_valid),
        .req_dir   (dir_req),
        .cur_dir   (dir_q),
        .pop       (q_pop),
        .head      (q_head),
        .not_empty (q_not_empty)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        req_d   = req_q;
        px_d    = px_q;
        py_d    = py_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lfsr_d  = lfsr_q;
        q_pop   = 1'b0;
        q_clear = 1'b0;
`ifdef SPEEDUP_EN
        period_d = period_q;
`endif

        if (state_q == ST_PLAY) begin
            if (cnt_q == cur_period - CNT_W'(1)) begin
                tick_d = 1'b1;
                cnt_d  = '0;
                if (q_not_empty) begin
                    dir_d = q_head;
                    q_pop = 1'b1;
                end
`ifdef SPEEDUP_EN
                period_d = speed_period(gift_count);
`endif
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                lfsr_d = lfsr_advance(lfsr_q);
                if (btn_start) state_d = ST_PLACE;
            end
            ST_PLACE: begin
                // A low request in PLACE means a fresh candidate goes out next cycle.
                if (!req_q) begin
                    req_d = 1'b1;
                    px_d  = cand_x;
                    py_d  = cand_y;
                end else if (place_ack) begin
                    req_d = 1'b0;
                    if (place_ok) begin
                        state_d = ST_PLAY;
                        retry_d = '0;
                        cnt_d   = '0;
`ifdef SPEEDUP_EN
                        period_d = speed_period(gift_count);
`endif
                    end else begin
                        lfsr_d  = lfsr_advance(lfsr_q);
                        retry_d = retry_q + RETRY_W'(1);
                        if (retry_q == RETRY_W'(MAX_RETRY - 1)) state_d = ST_OVER;
                    end
                end
            end
            ST_PLAY: begin
                if (game_over_in)                      state_d = ST_OVER;
                else if (gift_count >= 8'(WIN_COUNT))  state_d = ST_WIN;
                else if (gift_eaten)                   state_d = ST_PLACE;
                else if (btn_pause)                    state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (game_over_in)   state_d = ST_OVER;
                else if (btn_pause) state_d = ST_PLAY;
            end
            ST_OVER, ST_WIN: begin
                if (btn_start) begin
                    state_d = ST_IDLE;
                    q_clear = 1'b1;
                    dir_d   = DIR_RIGHT;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RIGHT;
            tick_q  <= 1'b0;
            req_q   <= 1'b0;
            px_q    <= 6'd20;
            py_q    <= 6'd20;
            cnt_q   <= '0;
            retry_q <= '0;
            lfsr_q  <= LFSR_SEED;
`ifdef SPEEDUP_EN
            period_q <= CNT_W'(TICK_DIV);
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            req_q   <= req_d;
            px_q    <= px_d;
            py_q    <= py_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            lfsr_q  <= lfsr_d;
`ifdef SPEEDUP_EN
            period_q <= period_d;
`endif
        end
    end

    assign place_req = req_q;
    assign place_x   = px_q;
    assign place_y   = py_q;
    assign move_tick = tick_q;
    assign direction = dir_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised bench for game_sequencer: a queue-based reference model predicts
// placements, ticks and per-cycle outputs; a monitor pops and compares them.
module tb_game_sequencer;

    localparam int TICK_DIV  = 8;
    localparam int WIN_COUNT = 10;
    localparam int MAX_RETRY = 64;
    localparam int TICK_STEP = 1;

    localparam int S_IDLE = 0, S_PLACE = 1, S_PLAY = 2, S_PAUSE = 3, S_OVER = 4, S_WIN = 5;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       dir_req_valid = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       gift_eaten = 1'b0;
    logic       game_over_in = 1'b0;
    logic [7:0] gift_count = 8'd0;
    logic       place_ack = 1'b0;
    logic       place_ok = 1'b0;
    logic       place_req;
    logic [5:0] place_x, place_y;
    logic       move_tick;
    logic [1:0] direction;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int ok_mode = 0;      // 0 accept, 1 reject, 2 random, 3 never answer
    bit spurious_en = 0;

    int          m_state, m_dir, m_x, m_y, m_cnt, m_retry, m_period;
    bit          m_req, m_tick;
    logic [15:0] m_lfsr;
    int          m_dirq[$];
    int          exp_place[$];
    int          exp_tick[$];

    always #5 vga_clk = ~vga_clk;

    game_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .WIN_COUNT (WIN_COUNT),
        .MAX_RETRY (MAX_RETRY),
        .TICK_STEP (TICK_STEP)
    ) dut (
        .vga_clk       (vga_clk),
        .reset         (reset),
        .btn_start     (btn_start),
        .btn_pause     (btn_pause),
        .dir_req_valid (dir_req_valid),
        .dir_req       (dir_req),
        .gift_eaten    (gift_eaten),
        .game_over_in  (game_over_in),
        .gift_count    (gift_count),
        .place_req     (place_req),
        .place_x       (place_x),
        .place_y       (place_y),
        .place_ack     (place_ack),
        .place_ok      (place_ok),
        .move_tick     (move_tick),
        .direction     (direction),
        .state         (state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

`ifdef SPEEDUP_EN
    function automatic int speed_period(input int gc);
        int lvl;
        lvl = gc / 2;
        if (lvl > 7) lvl = 7;
        return TICK_DIV - lvl * TICK_STEP;
    endfunction
`endif

    task automatic model_reset();
        m_state = S_IDLE; m_dir = 2; m_req = 0; m_tick = 0;
        m_x = 20; m_y = 20; m_cnt = 0; m_retry = 0;
        m_lfsr = 16'hACE1; m_period = TICK_DIV;
        m_dirq.delete(); exp_place.delete(); exp_tick.delete();
    endtask

    task automatic model_step();
        int cur, tail;
        bit do_push;
        cur = m_state;
        m_tick = 0;
        do_push = 0;
        if (dir_req_valid && (cur == S_PLAY || cur == S_PLACE)) begin
            tail = (m_dirq.size() == 0) ? m_dir : m_dirq[$];
            do_push = (m_dirq.size() < 2) && (int'(dir_req) != tail) && ((int'(dir_req) ^ tail) != 2);
        end
        if (cur == S_PLAY) begin
            if (m_cnt == m_period - 1) begin
                m_tick = 1;
                m_cnt = 0;
                if (m_dirq.size() > 0) m_dir = m_dirq.pop_front();
                exp_tick.push_back(m_dir);
`ifdef SPEEDUP_EN
                m_period = speed_period(int'(gift_count));
`endif
            end else begin
                m_cnt++;
            end
        end
        if (do_push) m_dirq.push_back(int'(dir_req));
        case (cur)
            S_IDLE: begin
                m_lfsr = lfsr_next(m_lfsr);
                if (btn_start) m_state = S_PLACE;
            end
            S_PLACE: begin
                if (!m_req) begin
                    m_req = 1;
                    m_x = int'(m_lfsr) % 64;
                    if (m_x >= 40) m_x -= 40;
                    m_y = (int'(m_lfsr) / 256) % 32;
                    if (m_y >= 30) m_y -= 30;
                    exp_place.push_back(m_x * 64 + m_y);
                end else if (place_ack) begin
                    m_req = 0;
                    if (place_ok) begin
                        m_state = S_PLAY;
                        m_retry = 0;
                        m_cnt = 0;
`ifdef SPEEDUP_EN
                        m_period = speed_period(int'(gift_count));
`endif
                    end else begin
                        m_lfsr = lfsr_next(m_lfsr);
                        m_retry++;
                        if (m_retry == MAX_RETRY) m_state = S_OVER;
                    end
                end
            end
            S_PLAY: begin
                if (game_over_in) m_state = S_OVER;
                else if (int'(gift_count) >= WIN_COUNT) m_state = S_WIN;
                else if (gift_eaten) m_state = S_PLACE;
                else if (btn_pause) m_state = S_PAUSE;
            end
            S_PAUSE: begin
                if (game_over_in) m_state = S_OVER;
                else if (btn_pause) m_state = S_PLAY;
            end
            default: begin
                if (btn_start) begin
                    m_state = S_IDLE;
                    m_dirq.delete();
                    m_dir = 2;
                    m_cnt = 0;
                    m_retry = 0;
                end
            end
        endcase
    endtask

    // Reference model
    initial begin
        forever begin
            @(posedge vga_clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // Placement checker
    initial begin
        forever begin
            @(posedge vga_clk);
            #1;
            place_ack = 1'b0;
            place_ok  = 1'b0;
            if (ok_mode != 3) begin
                if (place_req && $urandom_range(0, 1) == 1) begin
                    place_ack = 1'b1;
                    place_ok  = (ok_mode == 0) ? 1'b1 : (ok_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                end else if (!place_req && spurious_en && $urandom_range(0, 7) == 0) begin
                    place_ack = 1'b1;
                    place_ok  = 1'b1;
                end
            end
        end
    end

    // Monitor
    initial begin
        bit prev_req;
        int e, act, exp;
        prev_req = 0;
        forever begin
            @(negedge vga_clk);
            act = int'({state, place_req, move_tick, direction, place_x, place_y});
            exp = (m_state << 16) | (int'(m_req) << 15) | (int'(m_tick) << 14) |
                  (m_dir << 12) | (m_x << 6) | m_y;
            check("outputs", act, exp);
            if (place_req && !prev_req) begin
                check("place_queued", int'(exp_place.size() > 0), 1);
                if (exp_place.size() > 0) begin
                    e = exp_place.pop_front();
                    $display("[TB] place x=%0d y=%0d", place_x, place_y);
                    check("place_xy", int'(place_x) * 64 + int'(place_y), e);
                end
            end
            if (move_tick) begin
                check("tick_queued", int'(exp_tick.size() > 0), 1);
                if (exp_tick.size() > 0) begin
                    e = exp_tick.pop_front();
                    $display("[TB] tick dir=%0d", direction);
                    check("tick_dir", int'(direction), e);
                end
            end
            prev_req = place_req;
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        btn_start = 1'b1; step(); btn_start = 1'b0;
    endtask

    task automatic pulse_pause();
        btn_pause = 1'b1; step(); btn_pause = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (int'(state) == s) break;
            step();
        end
        check(name, int'(state), s);
    endtask

    task automatic wait_tick(input int budget, input string name, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!move_tick && cycles < budget);
        check(name, int'(move_tick), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, int'(state), S_IDLE);
        check({tag, "_dir"}, int'(direction), 2);
        check({tag, "_tick"}, int'(move_tick), 0);
        check({tag, "_req"}, int'(place_req), 0);
        check({tag, "_x"}, int'(place_x), 20);
        check({tag, "_y"}, int'(place_y), 20);
    endtask

    initial begin
        int cyc, ticks;

        reset = 1'b0;
        step(2);
        check_reset_values("por");
        reset = 1'b1;
        step(3);

        // First placement accepted
        ok_mode = 0;
        pulse_start();
        check("enter_place", int'(state), S_PLACE);
        check("req_low_on_entry", int'(place_req), 0);
        step();
        check("req_rises", int'(place_req), 1);
        check("x_in_range", int'(place_x < 6'd40), 1);
        check("y_in_range", int'(place_y < 6'd30), 1);
        wait_state(S_PLAY, 40, "play_after_ok");

        // Direction filter: left rejected, up queued, down rejected
        dir_req_valid = 1'b1; dir_req = 2'd0; step();
        dir_req = 2'd1; step();
        dir_req = 2'd3; step();
        dir_req_valid = 1'b0;
        wait_tick(3 * TICK_DIV, "tick_after_dirs", cyc);
        check("dir_after_tick", int'(direction), 1);
        wait_tick(3 * TICK_DIV, "tick_period", cyc);
        check("tick_spacing", cyc, TICK_DIV);

        // Pause freezes ticks
        pulse_pause();
        check("paused", int'(state), S_PAUSE);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (move_tick) ticks++;
        end
        check("no_tick_in_pause", ticks, 0);
        pulse_pause();
        check("resumed", int'(state), S_PLAY);
        step(5);

        // Gift eaten, then collision wins over a simultaneous gift
        gift_eaten = 1'b1; step(); gift_eaten = 1'b0;
        check("gift_to_place", int'(state), S_PLACE);
        wait_state(S_PLAY, 40, "play_after_gift");
        gift_eaten = 1'b1; game_over_in = 1'b1; step();
        gift_eaten = 1'b0;
        check("over_beats_gift", int'(state), S_OVER);
        game_over_in = 1'b0;
        pulse_start();
        check("restart_idle", int'(state), S_IDLE);
        check("restart_dir", int'(direction), 2);

        // Win on gift count
        pulse_start();
        wait_state(S_PLAY, 40, "play_for_win");
        gift_count = 8'd10; step();
        check("win", int'(state), S_WIN);
        gift_count = 8'd0;
        pulse_start();

        // Board full after repeated rejections
        ok_mode = 1;
        pulse_start();
        wait_state(S_OVER, 1500, "board_full_over");
        ok_mode = 0;
        pulse_start();

        // Reset while a request is outstanding
        ok_mode = 3;
        pulse_start();
        step();
        check("req_outstanding", int'(place_req), 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid");
        step(2);
        reset = 1'b1;
        ok_mode = 0;
        step(2);

        // Random play
        ok_mode = 2;
        spurious_en = 1;
        for (int i = 0; i < 2500; i++) begin
            btn_start     = ($urandom_range(0, 39) == 0);
            btn_pause     = ($urandom_range(0, 29) == 0);
            dir_req_valid = ($urandom_range(0, 2) == 0);
            dir_req       = 2'($urandom_range(0, 3));
            gift_eaten    = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 199) == 0) game_over_in = 1'b1;
            else if ($urandom_range(0, 3) == 0) game_over_in = 1'b0;
            if ($urandom_range(0, 49) == 0) gift_count = 8'($urandom_range(0, 12));
            step();
        end
        btn_start = 1'b0; btn_pause = 1'b0; dir_req_valid = 1'b0;
        gift_eaten = 1'b0; game_over_in = 1'b0; spurious_en = 0;
        step(2);
        @(negedge vga_clk);
        #1;
        check("place_leftover", exp_place.size(), 0);
        check("tick_leftover", exp_tick.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level play controller for the Grinch tile game on the 40x30 grid.
- Sequences the round through idle, gift placement, play, pause, over and win.
- Generates the one-cycle move tick that advances the Grinch.
- Filters and queues player direction requests.
- Proposes pseudo-random gift cells to the wall/occupancy checker over a req/ack handshake.
- Sits between the input/debounce logic and the game datapath, replacing the free-running update clock.

Parameters:
TICK_DIV, 1562500, vga_clk cycles per move tick (16 Hz at 25 MHz)
GRID_W, 40, grid columns
GRID_H, 30, grid rows
WIN_COUNT, 10, gift count that wins the round
MAX_RETRY, 64, rejected placements before declaring the board full
TICK_STEP, 62500, tick-period reduction per speed level (used only with SPEEDUP_EN)

Ports:
vga_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_start  in  1  one-cycle start/restart pulse
btn_pause  in  1  one-cycle pause-toggle pulse
dir_req_valid  in  1  direction request strobe
dir_req  in  2  00 left, 01 up, 10 right, 11 down
gift_eaten  in  1  one-cycle pulse from datapath: Grinch on gift
game_over_in  in  1  level from datapath: wall collision
gift_count  in  8  gifts collected
place_req  out  1  gift placement request
place_x  out  6  candidate/current gift column
place_y  out  6  candidate/current gift row
place_ack  in  1  checker response valid
place_ok  in  1  candidate cell free (valid with place_ack)
move_tick  out  1  one-cycle advance pulse
direction  out  2  current heading
state  out  3  IDLE=0 PLACE=1 PLAY=2 PAUSE=3 OVER=4 WIN=5

Behaviour:
Reset values:
- state IDLE, direction 10, move_tick 0, place_req 0, place_x 20, place_y 20.
- Tick counter 0, queue empty, retry count 0, LFSR 16'hACE1.

State transitions:
- IDLE: btn_start -> PLACE.
- PLACE: exits as defined under Placement.
- PLAY: transitions in priority order; same-cycle conflicts resolve by this priority:
  1. game_over_in -> OVER
  2. gift_count >= WIN_COUNT -> WIN
  3. gift_eaten -> PLACE
  4. btn_pause -> PAUSE
- PAUSE: btn_pause -> PLAY; game_over_in -> OVER. Tick counter frozen; direction requests dropped.
- OVER/WIN: btn_start -> IDLE; clears queue, sets direction 10, resets tick counter and retry count.
- btn_start outside IDLE/OVER/WIN is ignored.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in IDLE and on each rejection.

Placement:
- Candidate x = lfsr[5:0], minus 40 if >= 40.
- Candidate y = lfsr[12:8], minus 30 if >= 30.
- place_req rises the cycle after PLACE entry. place_x/place_y are held stable while place_req=1.
- place_ack & place_ok: drop place_req, keep coordinates, go to PLAY, clear retry count.
- place_ack & ~place_ok: drop place_req one cycle, advance LFSR, increment retry count, reissue.
- Retry count reaching MAX_RETRY -> OVER.
- place_ack while place_req=0 is ignored.

Move tick:
- In PLAY, counter counts 0..period-1; period = TICK_DIV.
- At terminal count, on the same edge: move_tick <= 1 and direction <= queue head (pop) if the queue is non-empty.
- move_tick is 0 in every other cycle and state. Counter resets on PLACE exit.

Direction queue (2 entries):
- Request compared against the last queued entry, or against direction when the queue is empty.
- Rejected if equal, opposite (differs only in bit 1), or queue full.
- Accepted only in PLAY and PLACE.
- Push and pop in the same cycle are both honoured; the pushed value is compared against the pre-pop tail.

Reset mid-operation: asynchronously forces all reset values, including place_req=0 during an outstanding request.

Optional Feature:
SPEEDUP_EN
- Defined: period = TICK_DIV - min(gift_count>>1, 7)*TICK_STEP, sampled at counter wrap.
- Undefined: period is constant TICK_DIV.

Decomposition:
- Package game_pkg holds:
  - state enum
  - DIR_LEFT/UP/RIGHT/DOWN constants
  - GRID_W, GRID_H
  - opposite-direction function
- Sub-module dir_queue: 2-entry FIFO with equal/reversal filter.

Test Plan:
- Reset, btn_start, checker acks ok=1 on the first request -> place_req high 1 cycle after PLACE entry; state PLAY; place_x/y = LFSR-derived in-range values.
- TICK_DIV=8 in PLAY -> move_tick high exactly every 8th cycle; no pulses in PAUSE; resumes at the frozen count after unpause.
- direction=10; requests 00 then 01 then 11 in consecutive cycles -> 00 rejected, 01 queued, 11 rejected; next tick direction=01.
- Checker returns ok=0 64 times -> state OVER; place_req never held across an ack.
- gift_eaten and game_over_in in the same cycle -> OVER, no PLACE; gift_count=10 in PLAY -> WIN; btn_start -> IDLE with direction 10.
- Reset pulsed during an outstanding place_req -> all outputs at reset values immediately; with SPEEDUP_EN and gift_count=4, TICK_DIV=100, TICK_STEP=10 -> tick period 80.
